// File: rtl/toggle_vector_monitor.sv
// Checks that every lane of an upstream self-toggling counter array inverts each cycle,
// keeping a sticky lane mask, a saturating error count and a first-failure snapshot.
module toggle_vector_monitor #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ERR_CNT_W  = 16,
  parameter int unsigned ARM_CYCLES = 2
) (
  input  logic                 c,
  input  logic                 r,
  input  logic [WIDTH-1:0]     a_in,
  input  logic                 en,
  input  logic                 clr,
  output logic [1:0]           state,
  output logic [WIDTH-1:0]     err_mask,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 snap_valid,
  input  logic                 snap_ready,
  output logic [WIDTH-1:0]     snap_data,
  output logic [WIDTH-1:0]     snap_mask,
  output logic [ERR_CNT_W-1:0] snap_cycle
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArm   = 2'd1,
    StCheck = 2'd2
  } state_e;

  localparam int unsigned ArmW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [ArmW-1:0] ArmLast = ArmW'(ARM_CYCLES - 1);
  localparam logic [ERR_CNT_W-1:0] CntMax = '1;

  state_e                 state_q, state_d;
  logic [ArmW-1:0]        arm_q, arm_d;
  logic [ERR_CNT_W-1:0]   cyc_q, cyc_d;
  logic [WIDTH-1:0]       prev_q;
  logic [WIDTH-1:0]       mask_q, mask_d;
  logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   sv_q, sv_d;
  logic [WIDTH-1:0]       sd_q, sd_d;
  logic [WIDTH-1:0]       sm_q, sm_d;
  logic [ERR_CNT_W-1:0]   sc_q, sc_d;

  logic [WIDTH-1:0]       mismatch;
  logic                   hit;
  logic                   slot_free;

  // Phase-agnostic: a lane is good when it is the inverse of its previous sample.
  assign mismatch  = (state_q == StCheck) ? (a_in ^ ~prev_q) : '0;
  assign hit       = |mismatch;
  assign slot_free = !sv_q || snap_ready;

  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    cyc_d   = cyc_q;
    case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StArm;
          arm_d   = '0;
        end
      end
      StArm: begin
        if (!en) begin
          state_d = StIdle;
        end else if (arm_q == ArmLast) begin
          state_d = StCheck;
          cyc_d   = '0;
        end else begin
          arm_d = arm_q + ArmW'(1);
        end
      end
      StCheck: begin
        if (cyc_q != CntMax) cyc_d = cyc_q + ERR_CNT_W'(1);
        if (!en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mask_d = mask_q;
    cnt_d  = cnt_q;
    sv_d   = sv_q;
    sd_d   = sd_q;
    sm_d   = sm_q;
    sc_d   = sc_q;
    if (clr) begin
      // A mismatch in the clearing cycle is intentionally dropped.
      mask_d = '0;
      cnt_d  = '0;
      sv_d   = 1'b0;
      sd_d   = '0;
      sm_d   = '0;
      sc_d   = '0;
    end else begin
      if (sv_q && snap_ready) sv_d = 1'b0;
      if (hit) begin
        mask_d = mask_q | mismatch;
        if (cnt_q != CntMax) cnt_d = cnt_q + ERR_CNT_W'(1);
        if (slot_free) begin
          sv_d = 1'b1;
          sd_d = a_in;
          sm_d = mismatch;
          sc_d = cyc_q;
        end
      end
    end
  end

  always_ff @(posedge c) begin
    if (r) begin
      state_q <= StIdle;
      arm_q   <= '0;
      cyc_q   <= '0;
      prev_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      sv_q    <= 1'b0;
      sd_q    <= '0;
      sm_q    <= '0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      cyc_q   <= cyc_d;
      prev_q  <= a_in;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      sv_q    <= sv_d;
      sd_q    <= sd_d;
      sm_q    <= sm_d;
      sc_q    <= sc_d;
    end
  end

  assign state      = state_q;
  assign err_mask   = mask_q;
  assign err_cnt    = cnt_q;
  assign snap_valid = sv_q;
  assign snap_data  = sd_q;
  assign snap_mask  = sm_q;
  assign snap_cycle = sc_q;

endmodule

// File: tb/tb_toggle_vector_monitor.sv
// Directed bench for toggle_vector_monitor: a reference model feeds a scoreboard every cycle,
// plus spot checks of the documented scenarios and a 4-bit-counter saturation instance.
module tb_toggle_vector_monitor;

  logic        c = 1'b0;
  logic        r, en, clr, snap_ready;
  logic [31:0] a_in;
  logic [1:0]  state;
  logic [31:0] err_mask, snap_data, snap_mask;
  logic [15:0] err_cnt, snap_cycle;
  logic        snap_valid;

  logic        en4;
  logic [31:0] a4;
  logic [1:0]  state4;
  logic [31:0] err_mask4, snap_data4, snap_mask4;
  logic [3:0]  err_cnt4, snap_cycle4;
  logic        snap_valid4;
  logic        zero4 = 1'b0;

  toggle_vector_monitor dut (
    .c(c), .r(r), .a_in(a_in), .en(en), .clr(clr), .state(state),
    .err_mask(err_mask), .err_cnt(err_cnt), .snap_valid(snap_valid),
    .snap_ready(snap_ready), .snap_data(snap_data), .snap_mask(snap_mask),
    .snap_cycle(snap_cycle)
  );

  toggle_vector_monitor #(.ERR_CNT_W(4)) dut4 (
    .c(c), .r(r), .a_in(a4), .en(en4), .clr(zero4), .state(state4),
    .err_mask(err_mask4), .err_cnt(err_cnt4), .snap_valid(snap_valid4),
    .snap_ready(zero4), .snap_data(snap_data4), .snap_mask(snap_mask4),
    .snap_cycle(snap_cycle4)
  );

  always #5 c = ~c;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] mask;
    logic [15:0] cnt;
    logic        sv;
    logic [31:0] sd;
    logic [31:0] sm;
    logic [15:0] sc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_a = '0;

  logic [1:0]  m_state = '0;
  logic [31:0] m_prev = '0, m_mask = '0, m_sd = '0, m_sm = '0;
  logic [15:0] m_cyc = '0, m_cnt = '0, m_sc = '0;
  logic        m_arm = 1'b0, m_sv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the reference model, then compare after the edge.
  task automatic step(input logic [31:0] a, input logic rr, input logic ee, input logic cc,
                      input logic rdy);
    exp_t e;
    logic [31:0] mm;
    logic free;
    a_in = a; r = rr; en = ee; clr = cc; snap_ready = rdy;
    if (rr) begin
      m_state = 0; m_prev = 0; m_mask = 0; m_sd = 0; m_sm = 0;
      m_cyc = 0; m_cnt = 0; m_sc = 0; m_arm = 0; m_sv = 0;
    end else begin
      mm = (m_state == 2'd2) ? (a ^ ~m_prev) : 32'h0;
      free = !m_sv || rdy;
      if (cc) begin
        m_mask = 0; m_cnt = 0; m_sv = 0; m_sd = 0; m_sm = 0; m_sc = 0;
      end else begin
        if (m_sv && rdy) m_sv = 0;
        if (mm != 0) begin
          m_mask = m_mask | mm;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          if (free) begin
            m_sv = 1; m_sd = a; m_sm = mm; m_sc = m_cyc;
          end
        end
      end
      case (m_state)
        2'd0: if (ee) begin m_state = 2'd1; m_arm = 0; end
        2'd1: begin
          if (!ee) m_state = 2'd0;
          else if (m_arm) begin m_state = 2'd2; m_cyc = 0; end
          else m_arm = 1;
        end
        default: begin
          if (m_cyc != 16'hFFFF) m_cyc = m_cyc + 16'd1;
          if (!ee) m_state = 2'd0;
        end
      endcase
      m_prev = a;
    end
    e.st = m_state; e.mask = m_mask; e.cnt = m_cnt; e.sv = m_sv;
    e.sd = m_sd; e.sm = m_sm; e.sc = m_sc;
    sb.push_back(e);
    @(posedge c);
    #1;
    e = sb.pop_front();
    chk("sb_state", {30'd0, state}, {30'd0, e.st});
    chk("sb_err_mask", err_mask, e.mask);
    chk("sb_err_cnt", {16'd0, err_cnt}, {16'd0, e.cnt});
    chk("sb_snap_valid", {31'd0, snap_valid}, {31'd0, e.sv});
    chk("sb_snap_data", snap_data, e.sd);
    chk("sb_snap_mask", snap_mask, e.sm);
    chk("sb_snap_cycle", {16'd0, snap_cycle}, {16'd0, e.sc});
    last_a = a;
  endtask

  task automatic clean(input int n, input logic ee);
    for (int i = 0; i < n; i++) step(~last_a, 1'b0, ee, 1'b0, 1'b0);
  endtask

  task automatic stuck(input logic [31:0] lanes, input logic cc, input logic rdy);
    step(~last_a ^ lanes, 1'b0, 1'b1, cc, rdy);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cnt"}, {16'd0, err_cnt}, 32'd0);
    chk({tag, "_mask"}, err_mask, 32'd0);
    chk({tag, "_sv"}, {31'd0, snap_valid}, 32'd0);
  endtask

  initial begin
    en4 = 1'b0;
    a4  = 32'h1234_5678;
    // Reset with enable already high.
    for (int i = 0; i < 4; i++) step(32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk_zero("rst");
    chk("rst_snap_mask", snap_mask, 32'd0);
    chk("rst_snap_cycle", {16'd0, snap_cycle}, 32'd0);

    // Clean alternating run.
    clean(2, 1'b1);
    chk("arm_state", {30'd0, state}, 32'd1);
    clean(1, 1'b1);
    chk("check_state_edge3", {30'd0, state}, 32'd2);
    clean(97, 1'b1);
    chk("clean_state", {30'd0, state}, 32'd2);
    chk_zero("clean");

    // Single stuck lane at CHECK cycle 10.
    clean(1, 1'b0);
    clean(3, 1'b1);
    clean(10, 1'b1);
    stuck(32'h0000_0020, 1'b0, 1'b0);
    chk("lane5_cnt", {16'd0, err_cnt}, 32'd1);
    chk("lane5_mask", err_mask, 32'h0000_0020);
    chk("lane5_snap_mask", snap_mask, 32'h0000_0020);
    chk("lane5_snap_cycle", {16'd0, snap_cycle}, 32'd10);
    chk("lane5_snap_valid", {31'd0, snap_valid}, 32'd1);
    chk("lane5_snap_data", snap_data, last_a);

    // Snapshot hold, then accept with a simultaneous new capture.
    clean(1, 1'b0);
    step(~last_a, 1'b0, 1'b1, 1'b1, 1'b0);
    clean(12, 1'b1);
    stuck(32'h0000_0001, 1'b0, 1'b0);
    clean(1, 1'b1);
    stuck(32'h8000_0000, 1'b0, 1'b0);
    chk("hold_snap_mask", snap_mask, 32'h0000_0001);
    chk("hold_snap_cycle", {16'd0, snap_cycle}, 32'd10);
    chk("hold_err_mask", err_mask, 32'h8000_0001);
    chk("hold_err_cnt", {16'd0, err_cnt}, 32'd2);
    stuck(32'h0000_0008, 1'b0, 1'b1);
    chk("recap_valid", {31'd0, snap_valid}, 32'd1);
    chk("recap_snap_mask", snap_mask, 32'h0000_0008);
    chk("recap_snap_cycle", {16'd0, snap_cycle}, 32'd13);

    // clr beats a same-cycle lane-7 error.
    stuck(32'h0000_0080, 1'b1, 1'b0);
    chk_zero("clr");
    clean(1, 1'b1);
    chk_zero("clr_next");

    // Disable mid-CHECK retains errors; reset mid-CHECK with a snapshot pending.
    stuck(32'h0000_0002, 1'b0, 1'b0);
    clean(1, 1'b0);
    chk("dis_state", {30'd0, state}, 32'd0);
    chk("dis_cnt", {16'd0, err_cnt}, 32'd1);
    clean(6, 1'b1);
    stuck(32'h0000_0004, 1'b0, 1'b0);
    chk("pre_rst_state", {30'd0, state}, 32'd2);
    step(~last_a, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("midrst_state", {30'd0, state}, 32'd0);
    chk_zero("midrst");
    chk("midrst_snap_data", snap_data, 32'd0);
    chk("midrst_snap_cycle", {16'd0, snap_cycle}, 32'd0);

    // Saturation on the 4-bit-counter instance: constant input fails every lane.
    en4 = 1'b1;
    clean(23, 1'b0);
    chk("sat_state", {30'd0, state4}, 32'd2);
    chk("sat_cnt", {28'd0, err_cnt4}, 32'd15);
    chk("sat_mask", err_mask4, 32'hFFFF_FFFF);
    chk("sat_snap_cycle", {28'd0, snap_cycle4}, 32'd0);
    chk("sat_snap_valid", {31'd0, snap_valid4}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
